// File: rtl/slavefifo2b_pkg.sv
// rtl/slavefifo2b_pkg.sv - shared encodings for the Slave FIFO 2-bit pin controller
package slavefifo2b_pkg;

  // Engine selection as seen on the mode_sel switch
  typedef enum logic [1:0] {
    MODE_NONE       = 2'b00,
    MODE_LOOPBACK   = 2'b01,
    MODE_STREAM_IN  = 2'b10,
    MODE_STREAM_OUT = 2'b11
  } mode_e;

  // FX3 socket addresses: producer socket takes FPGA writes, consumer socket feeds FPGA reads
  localparam logic [1:0] FADDR_PROD = 2'b00;
  localparam logic [1:0] FADDR_CONS = 2'b11;

  // Mode FSM states
  typedef enum logic [1:0] {
    M_IDLE   = 2'b00,
    M_ACTIVE = 2'b01,
    M_DRAIN  = 2'b10,
    M_GAP    = 2'b11
  } mode_state_e;

endpackage

// File: rtl/slavefifo2b_pin_ctrl_sync2.sv
// rtl/slavefifo2b_pin_ctrl_sync2.sv - generic two-flop synchronizer
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Two back-to-back flops; the first may go metastable, the second resolves it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/slavefifo2b_pin_ctrl.sv
// rtl/slavefifo2b_pin_ctrl.sv - FX3 pin front end: flag/data capture, engine mux, mode FSM
module slavefifo2b_pin_ctrl
  import slavefifo2b_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic              clk_100,
  input  logic              reset_,
  input  logic [1:0]        mode_sel,
  input  logic              flaga,
  input  logic              flagb,
  input  logic              flagc,
  input  logic              flagd,
  input  logic [DATA_W-1:0] fdata_in,
  output logic              flaga_d,
  output logic              flagb_d,
  output logic              flagc_d,
  output logic              flagd_d,
  output logic [DATA_W-1:0] data_in_eng,
  output logic              loopback_mode_selected,
  output logic              stream_in_mode_selected,
  output logic              stream_out_mode_selected,
  input  logic              lb_slrd_,
  input  logic              lb_sloe_,
  input  logic              lb_slwr_,
  input  logic              lb_rd_select,
  input  logic [DATA_W-1:0] lb_data,
  input  logic              si_slwr_,
  input  logic              si_pktend_,
  input  logic [DATA_W-1:0] si_data,
  input  logic              so_slrd_,
  input  logic              so_sloe_,
  output logic              slcs_,
  output logic              slrd_,
  output logic              sloe_,
  output logic              slwr_,
  output logic              pktend_,
  output logic [1:0]        faddr,
  output logic [DATA_W-1:0] fdata_out,
  output logic              fdata_oe
);

  localparam logic [3:0] DRAIN_TARGET = 4'(DRAIN_CYCLES);

  logic [1:0]  mode_sync_raw;
  mode_e       mode_sync;
  mode_state_e state_q, state_d;
  mode_e       active_q, active_d;
  logic [3:0]  idle_cnt_q, idle_cnt_d;

  logic              eng_slrd, eng_sloe, eng_slwr, eng_pktend, eng_idle, engaged;
  logic [1:0]        eng_faddr;
  logic [DATA_W-1:0] eng_data;

  logic              slcs_q, slrd_q, sloe_q, slwr_q, pktend_q, fdata_oe_q;
  logic              slcs_d, slrd_d, sloe_d, slwr_d, pktend_d, fdata_oe_d;
  logic [1:0]        faddr_q, faddr_d;
  logic [DATA_W-1:0] fdata_out_q, fdata_out_d;
  logic [3:0]        flags_q;
  logic [DATA_W-1:0] data_in_q;

  sync2 #(.W(2)) u_mode_sync (
    .clk_i  (clk_100),
    .rst_ni (reset_),
    .d_i    (mode_sel),
    .q_o    (mode_sync_raw)
  );

  assign mode_sync = mode_e'(mode_sync_raw);

  // Capture FX3 flags and read data for the engines every cycle regardless of mode
  always_ff @(posedge clk_100 or negedge reset_) begin
    if (!reset_) begin
      flags_q   <= '0;
      data_in_q <= '0;
    end else begin
      flags_q   <= {flaga, flagb, flagc, flagd};
      data_in_q <= fdata_in;
    end
  end

  // Active engine view; signals an engine lacks read as deasserted (1)
  always_comb begin
    eng_slrd   = 1'b1;
    eng_sloe   = 1'b1;
    eng_slwr   = 1'b1;
    eng_pktend = 1'b1;
    eng_faddr  = FADDR_PROD;
    eng_data   = '0;
    case (active_q)
      MODE_LOOPBACK: begin
        eng_slrd  = lb_slrd_;
        eng_sloe  = lb_sloe_;
        eng_slwr  = lb_slwr_;
        eng_faddr = lb_rd_select ? FADDR_CONS : FADDR_PROD;
        eng_data  = lb_data;
      end
      MODE_STREAM_IN: begin
        eng_slwr   = si_slwr_;
        eng_pktend = si_pktend_;
        eng_faddr  = FADDR_PROD;
        eng_data   = si_data;
      end
      MODE_STREAM_OUT: begin
        eng_slrd  = so_slrd_;
        eng_sloe  = so_sloe_;
        eng_faddr = FADDR_CONS;
      end
      default: ;
    endcase
    eng_idle = eng_slrd & eng_sloe & eng_slwr & eng_pktend;
    engaged  = (state_q == M_ACTIVE) || (state_q == M_DRAIN);
  end

  // Mode FSM next state: hold the engine on the pins until its strobes stay idle long enough
  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    idle_cnt_d = '0;
    case (state_q)
      M_IDLE: begin
        if (mode_sync != MODE_NONE) begin
          active_d = mode_sync;
          state_d  = M_ACTIVE;
        end
      end
      M_ACTIVE: begin
        if (mode_sync != active_q) state_d = M_DRAIN;
      end
      M_DRAIN: begin
        if (eng_idle) begin
          idle_cnt_d = idle_cnt_q + 4'd1;
          if (idle_cnt_d == DRAIN_TARGET) begin
            idle_cnt_d = '0;
            state_d    = M_GAP;
          end
        end
      end
      M_GAP: state_d = M_IDLE;
      default: state_d = M_IDLE;
    endcase
  end

  // Mode FSM state, latched engine and idle counter
  always_ff @(posedge clk_100 or negedge reset_) begin
    if (!reset_) begin
      state_q    <= M_IDLE;
      active_q   <= MODE_NONE;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      active_q   <= active_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  // Pin next values; output enable waits for the registered sloe_ to be high so the bus turns around cleanly
  always_comb begin
    slcs_d      = 1'b1;
    slrd_d      = 1'b1;
    sloe_d      = 1'b1;
    slwr_d      = 1'b1;
    pktend_d    = 1'b1;
    faddr_d     = FADDR_PROD;
    fdata_out_d = '0;
    fdata_oe_d  = 1'b0;
    if (engaged) begin
      slcs_d      = 1'b0;
      slrd_d      = eng_slrd;
      sloe_d      = eng_sloe;
      slwr_d      = eng_slwr;
      pktend_d    = eng_pktend;
      faddr_d     = eng_faddr;
      fdata_out_d = eng_data;
      fdata_oe_d  = ((active_q == MODE_LOOPBACK) || (active_q == MODE_STREAM_IN))
                    && eng_sloe && sloe_q;
    end
  end

  // Registered pin outputs
  always_ff @(posedge clk_100 or negedge reset_) begin
    if (!reset_) begin
      slcs_q      <= 1'b1;
      slrd_q      <= 1'b1;
      sloe_q      <= 1'b1;
      slwr_q      <= 1'b1;
      pktend_q    <= 1'b1;
      faddr_q     <= FADDR_PROD;
      fdata_out_q <= '0;
      fdata_oe_q  <= 1'b0;
    end else begin
      slcs_q      <= slcs_d;
      slrd_q      <= slrd_d;
      sloe_q      <= sloe_d;
      slwr_q      <= slwr_d;
      pktend_q    <= pktend_d;
      faddr_q     <= faddr_d;
      fdata_out_q <= fdata_out_d;
      fdata_oe_q  <= fdata_oe_d;
    end
  end

  assign {flaga_d, flagb_d, flagc_d, flagd_d} = flags_q;
  assign data_in_eng = data_in_q;

  assign loopback_mode_selected   = (state_q == M_ACTIVE) && (active_q == MODE_LOOPBACK);
  assign stream_in_mode_selected  = (state_q == M_ACTIVE) && (active_q == MODE_STREAM_IN);
  assign stream_out_mode_selected = (state_q == M_ACTIVE) && (active_q == MODE_STREAM_OUT);

  assign slcs_     = slcs_q;
  assign slrd_     = slrd_q;
  assign sloe_     = sloe_q;
  assign slwr_     = slwr_q;
  assign pktend_   = pktend_q;
  assign faddr     = faddr_q;
  assign fdata_out = fdata_out_q;
  assign fdata_oe  = fdata_oe_q;

endmodule

// File: tb/tb_slavefifo2b_pin_ctrl.sv
// tb/tb_slavefifo2b_pin_ctrl.sv - randomized self-checking bench for slavefifo2b_pin_ctrl
module tb_slavefifo2b_pin_ctrl;

  localparam int DW    = 32;
  localparam int DRAIN = 4;

  logic          clk_100 = 1'b0;
  logic          reset_;
  logic [1:0]    mode_sel;
  logic          flaga, flagb, flagc, flagd;
  logic [DW-1:0] fdata_in;
  logic          flaga_d, flagb_d, flagc_d, flagd_d;
  logic [DW-1:0] data_in_eng;
  logic          loopback_mode_selected, stream_in_mode_selected, stream_out_mode_selected;
  logic          lb_slrd_, lb_sloe_, lb_slwr_, lb_rd_select;
  logic [DW-1:0] lb_data;
  logic          si_slwr_, si_pktend_;
  logic [DW-1:0] si_data;
  logic          so_slrd_, so_sloe_;
  logic          slcs_, slrd_, sloe_, slwr_, pktend_;
  logic [1:0]    faddr;
  logic [DW-1:0] fdata_out;
  logic          fdata_oe;
  logic [2:0]    sel_vec;

  assign sel_vec = {loopback_mode_selected, stream_in_mode_selected, stream_out_mode_selected};

  slavefifo2b_pin_ctrl #(.DATA_W(DW), .DRAIN_CYCLES(DRAIN)) dut (
    .clk_100(clk_100), .reset_(reset_), .mode_sel(mode_sel),
    .flaga(flaga), .flagb(flagb), .flagc(flagc), .flagd(flagd), .fdata_in(fdata_in),
    .flaga_d(flaga_d), .flagb_d(flagb_d), .flagc_d(flagc_d), .flagd_d(flagd_d),
    .data_in_eng(data_in_eng),
    .loopback_mode_selected(loopback_mode_selected),
    .stream_in_mode_selected(stream_in_mode_selected),
    .stream_out_mode_selected(stream_out_mode_selected),
    .lb_slrd_(lb_slrd_), .lb_sloe_(lb_sloe_), .lb_slwr_(lb_slwr_),
    .lb_rd_select(lb_rd_select), .lb_data(lb_data),
    .si_slwr_(si_slwr_), .si_pktend_(si_pktend_), .si_data(si_data),
    .so_slrd_(so_slrd_), .so_sloe_(so_sloe_),
    .slcs_(slcs_), .slrd_(slrd_), .sloe_(sloe_), .slwr_(slwr_), .pktend_(pktend_),
    .faddr(faddr), .fdata_out(fdata_out), .fdata_oe(fdata_oe)
  );

  always #5 clk_100 = ~clk_100;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: what the pins should look like, derived from the behavioural rules
  int            m_phase;     // 0 none engaged, 1 engine owns pins and is enabled, 2 draining, 3 gap
  logic [1:0]    m_eng;       // engine owning the pins
  logic [1:0]    m_hist [2];  // mode_sel as seen one and two edges ago
  int            m_quiet;     // consecutive quiet cycles seen while draining
  logic          e_slcs, e_slrd, e_sloe, e_slwr, e_pktend, e_oe;
  logic [1:0]    e_faddr;
  logic [DW-1:0] e_fdata, e_din;
  logic [3:0]    e_flags;

  task automatic model_reset();
    m_phase = 0; m_eng = 2'd0; m_hist[0] = 2'd0; m_hist[1] = 2'd0; m_quiet = 0;
    e_slcs = 1; e_slrd = 1; e_sloe = 1; e_slwr = 1; e_pktend = 1; e_oe = 0;
    e_faddr = 2'd0; e_fdata = '0; e_din = '0; e_flags = 4'd0;
  endtask

  task automatic model_edge();
    logic r, o, w, p, owns;
    logic [1:0] a;
    logic [DW-1:0] d;
    logic [1:0] seen;
    r = 1; o = 1; w = 1; p = 1; a = 2'd0; d = '0;
    if (m_eng == 2'd1) begin r = lb_slrd_; o = lb_sloe_; w = lb_slwr_; a = lb_rd_select ? 2'd3 : 2'd0; d = lb_data; end
    if (m_eng == 2'd2) begin w = si_slwr_; p = si_pktend_; d = si_data; end
    if (m_eng == 2'd3) begin r = so_slrd_; o = so_sloe_; a = 2'd3; end
    owns = (m_phase == 1) || (m_phase == 2);
    if (owns) begin
      e_oe = (m_eng == 2'd1 || m_eng == 2'd2) && o && e_sloe;
      e_slcs = 0; e_slrd = r; e_sloe = o; e_slwr = w; e_pktend = p; e_faddr = a; e_fdata = d;
    end else begin
      e_oe = 0; e_slcs = 1; e_slrd = 1; e_sloe = 1; e_slwr = 1; e_pktend = 1; e_faddr = 0; e_fdata = '0;
    end
    seen = m_hist[1];
    if (m_phase == 0) begin
      if (seen != 2'd0) begin m_eng = seen; m_phase = 1; end
    end else if (m_phase == 1) begin
      if (seen != m_eng) begin m_phase = 2; m_quiet = 0; end
    end else if (m_phase == 2) begin
      m_quiet = (r && o && w && p) ? m_quiet + 1 : 0;
      if (m_quiet == DRAIN) begin m_phase = 3; m_quiet = 0; end
    end else begin
      m_phase = 0;
    end
    m_hist[1] = m_hist[0];
    m_hist[0] = mode_sel;
    e_flags = {flaga, flagb, flagc, flagd};
    e_din   = fdata_in;
  endtask

  function automatic logic [2:0] exp_sel();
    if (m_phase != 1) return 3'b000;
    if (m_eng == 2'd1) return 3'b100;
    if (m_eng == 2'd2) return 3'b010;
    return 3'b001;
  endfunction

  task automatic check_all();
    check_eq("strobes", {slcs_, slrd_, sloe_, slwr_, pktend_}, {e_slcs, e_slrd, e_sloe, e_slwr, e_pktend});
    check_eq("faddr", faddr, e_faddr);
    check_eq("fdata_out", fdata_out, e_fdata);
    check_eq("fdata_oe", fdata_oe, e_oe);
    check_eq("flags_d", {flaga_d, flagb_d, flagc_d, flagd_d}, e_flags);
    check_eq("data_in_eng", data_in_eng, e_din);
    check_eq("mode_selected", sel_vec, exp_sel());
    check_eq("oe_with_sloe", fdata_oe & ~sloe_, 1'b0);
  endtask

  task automatic step();
    @(posedge clk_100);
    if (reset_) model_edge();
    #1;
    check_all();
  endtask

  task automatic set_idle();
    lb_slrd_ = 1; lb_sloe_ = 1; lb_slwr_ = 1; lb_rd_select = 0; lb_data = '0;
    si_slwr_ = 1; si_pktend_ = 1; si_data = '0;
    so_slrd_ = 1; so_sloe_ = 1;
  endtask

  task automatic wait_sel(input string tag, input logic [2:0] want, input int budget, output int cycles);
    int found;
    found = 0;
    cycles = 0;
    for (int i = 0; i < budget && found == 0; i++) begin
      step();
      cycles++;
      if (sel_vec == want) found = 1;
    end
    check_eq(tag, found, 1);
  endtask

  initial begin
    int n;
    reset_ = 0; mode_sel = 2'd0;
    flaga = 1; flagb = 1; flagc = 1; flagd = 1; fdata_in = 32'h1234_5678;
    set_idle();
    model_reset();

    // Reset state with flags high
    #22;
    check_all();
    check_eq("rst_slcs", slcs_, 1'b1);
    check_eq("rst_flags", {flaga_d, flagb_d, flagc_d, flagd_d}, 4'h0);
    reset_ = 1;
    step();
    check_eq("flags_after_rst", {flaga_d, flagb_d, flagc_d, flagd_d}, 4'hf);

    // Loopback selection latency
    mode_sel = 2'd1;
    step(); step();
    check_eq("lb_sel_early", sel_vec, 3'b000);
    step();
    check_eq("lb_sel_3cyc", sel_vec, 3'b100);

    // Loopback read from the consumer socket
    lb_rd_select = 1; lb_slrd_ = 0; lb_sloe_ = 0;
    step();
    check_eq("lb_rd_pins", {faddr, slrd_, sloe_, fdata_oe}, {2'b11, 1'b0, 1'b0, 1'b0});

    // One turnaround cycle, then a loopback write
    set_idle();
    step();
    lb_data = 32'hA5A5_0001; lb_slwr_ = 0;
    step();
    check_eq("lb_wr_pins", {slwr_, faddr, fdata_oe}, {1'b0, 2'b00, 1'b1});
    check_eq("lb_wr_data", fdata_out, 32'hA5A5_0001);

    // Switch to stream_in while loopback reads keep toggling
    mode_sel = 2'd2;
    for (int i = 0; i < 8; i++) begin
      lb_slrd_ = (i % 2 == 1) ? 1'b0 : 1'b1;
      lb_slwr_ = 1;
      step();
      if (i == 2) check_eq("lb_sel_fall", sel_vec, 3'b000);
    end
    set_idle();
    wait_sel("si_sel_reached", 3'b010, 20, n);
    check_eq("si_sel_cycles", n, DRAIN + 2);

    // Stream-out read turnaround
    mode_sel = 2'd3;
    wait_sel("so_sel_reached", 3'b001, 30, n);
    step();
    so_sloe_ = 0; so_slrd_ = 0;
    step();
    check_eq("so_sloe_oe", {sloe_, fdata_oe, faddr}, {1'b0, 1'b0, 2'b11});

    // Random traffic and mode changes
    for (int i = 0; i < 1000; i++) begin
      lb_slrd_ = ($urandom_range(7) != 0); lb_sloe_ = ($urandom_range(7) != 0);
      lb_slwr_ = ($urandom_range(7) != 0); lb_rd_select = $urandom_range(1);
      lb_data = $urandom; si_data = $urandom;
      si_slwr_ = ($urandom_range(7) != 0); si_pktend_ = ($urandom_range(7) != 0);
      so_slrd_ = ($urandom_range(7) != 0); so_sloe_ = ($urandom_range(7) != 0);
      {flaga, flagb, flagc, flagd} = 4'($urandom);
      fdata_in = $urandom;
      if ($urandom_range(39) == 0) mode_sel = 2'($urandom);
      step();
    end

    // Reset asserted in the middle of a loopback write
    set_idle();
    mode_sel = 2'd1;
    wait_sel("lb_sel_again", 3'b100, 60, n);
    lb_slwr_ = 0; lb_data = 32'hDEAD_BEEF;
    step();
    check_eq("mid_wr_slwr", slwr_, 1'b0);
    #3;
    reset_ = 0;
    #1;
    check_eq("async_rst_pins", {slwr_, slcs_, fdata_oe}, {1'b1, 1'b1, 1'b0});
    model_reset();
    check_all();
    #2;
    reset_ = 1;
    set_idle();
    mode_sel = 2'd0;
    for (int i = 0; i < 4; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/slavefifo2b_pin_ctrl.md
# slavefifo2b_pin_ctrl

Pin-side front end of the GPIF-II Slave FIFO 2-bit interface, between the FX3 pins and the mode engines (loopback, stream-in, stream-out). It registers the FX3 flags and the incoming data bus for the engines, and muxes the active engine's strobes, address and write data onto registered pin outputs. A mode FSM changes engines only after the active engine's strobes have been idle for a drain window, so a mode switch never cuts a transfer in half.

## Interface
Parameters:
- DATA_W, 32, data bus width
- DRAIN_CYCLES, 4, consecutive all-idle strobe cycles required before releasing a mode (1..15)

Ports:
- clk_100  in  1  100 MHz interface clock
- reset_  in  1  asynchronous, active-low
- mode_sel  in  2  asynchronous switch input: 00 none, 01 loopback, 10 stream_in, 11 stream_out
- flaga, flagb, flagc, flagd  in  1 each  raw FX3 flags
- fdata_in  in  DATA_W  FX3 data bus, input side of the IOBUF
- flaga_d, flagb_d, flagc_d, flagd_d  out  1 each  registered flags to the engines
- data_in_eng  out  DATA_W  registered fdata_in to the engines
- loopback_mode_selected, stream_in_mode_selected, stream_out_mode_selected  out  1 each  one-hot engine enables
- lb_slrd_, lb_sloe_, lb_slwr_, lb_rd_select, lb_data  in  1,1,1,1,DATA_W  loopback engine controls and write data
- si_slwr_, si_pktend_, si_data  in  1,1,DATA_W  stream-in engine controls and write data
- so_slrd_, so_sloe_  in  1,1  stream-out engine controls
- slcs_, slrd_, sloe_, slwr_, pktend_  out  1 each  FX3 strobes, active-low
- faddr  out  2  FX3 socket address
- fdata_out  out  DATA_W  write data to the IOBUF
- fdata_oe  out  1  IOBUF output enable; 1 = FPGA drives the bus

## Operation
- Input registers: flag*_d and data_in_eng are one flop after the pins. They update every cycle, whatever the mode.
- mode_sel passes through a 2-flop synchronizer to give mode_sync.
- Mode FSM states and transitions:
  - M_IDLE: if mode_sync != 00, latch active_mode and go to M_ACTIVE.
  - M_ACTIVE: drive the one-hot mode_selected for active_mode. If mode_sync != active_mode, go to M_DRAIN.
  - M_DRAIN: all mode_selected outputs low; the engine stays muxed to the pins. An idle counter increments while the active engine's slrd_, sloe_, slwr_ (and pktend_ for stream_in) are all 1, and clears otherwise. At DRAIN_CYCLES, go to M_GAP.
  - M_GAP: 1 cycle with pins forced idle, then M_IDLE.
- Pin mux. Engine inputs an engine does not have are treated as 1.
  - In M_ACTIVE/M_DRAIN, pins follow the active engine.
  - In M_IDLE/M_GAP: all strobes 1, slcs_ = 1, faddr = 00, fdata_oe = 0.
- slcs_ = 0 in M_ACTIVE and M_DRAIN.
- faddr:
  - loopback: 11 if lb_rd_select, else 00.
  - stream_in: 00.
  - stream_out: 11.
- fdata_out:
  - loopback: lb_data.
  - stream_in: si_data.
  - stream_out: 0.
- fdata_oe: 1 only when active_mode is loopback or stream_in, the engine's sloe_ is 1, and the registered sloe_ pin is 1.
- Reset values:
  - slcs_, slrd_, sloe_, slwr_, pktend_ = 1.
  - faddr = 00, fdata_out = 0, fdata_oe = 0.
  - flag*_d = 0, data_in_eng = 0.
  - all mode_selected = 0; FSM in M_IDLE; synchronizer and idle counter = 0.
- Reset mid-transfer: all outputs go to their reset values immediately. No drain is done.
- mode_sel changing back to active_mode while in M_DRAIN does not abort the drain; the FSM completes M_GAP and M_IDLE first.

## Timing
- Engine input to pin: 1 cycle (all pin outputs registered).
- Pin to flag*_d or data_in_eng: 1 cycle.
- mode_sel change to mode_selected falling: 3 cycles (2 synchronizer cycles + 1 FSM cycle).
- Bus turnaround:
  - fdata_oe falls on the same edge that sloe_ pin falls.
  - fdata_oe rises no earlier than 1 cycle after sloe_ pin rises.
  - fdata_oe and the sloe_ pin are never both asserted.
- Minimum mode switch: M_DRAIN lasts at least DRAIN_CYCLES cycles, plus 1 cycle of M_GAP and 1 cycle of M_IDLE before the new mode_selected.

## Structure
- Package slavefifo2b_pkg holds:
  - mode encodings MODE_NONE/LOOPBACK/STREAM_IN/STREAM_OUT
  - socket constants FADDR_PROD = 2'b00, FADDR_CONS = 2'b11
  - mode FSM state encodings.
- Sub-module sync2: a generic 2-flop synchronizer, instantiated once for mode_sel (width 2).
- Everything else is flat in this block.

## Test plan
- Reset with flaga..d = 1: all strobes 1, faddr = 00, fdata_oe = 0, flag*_d = 0. flag*_d = 1 one cycle after reset_ is released.
- mode_sel = 01: loopback_mode_selected rises 3 cycles later. lb_rd_select = 1 with lb_slrd_ = lb_sloe_ = 0 gives faddr = 11, slrd_ = sloe_ = 0 and fdata_oe = 0 one cycle later.
- Loopback write with lb_data = 32'hA5A5_0001 and lb_slwr_ = 0: next cycle slwr_ = 0, faddr = 00, fdata_out = A5A5_0001, fdata_oe = 1.
- Switch 01→10 while lb_slrd_ is toggling: mode_selected falls, pins keep following loopback until 4 consecutive idle cycles, then 1 idle gap cycle, then stream_in_mode_selected = 1.
- Stream-out: sloe_ pin 1→0 gives fdata_oe = 0 on the same edge. Check fdata_oe and the sloe_ pin are never both asserted for 1000 random cycles.
- Assert reset_ mid-write: slwr_ = 1, slcs_ = 1 and fdata_oe = 0 asynchronously, with no wait for a clock edge.
